// File: rtl/mmio_pkg.sv
// mmio_pkg: shared decode constants and reset values for the data-memory MMIO responder (optional MMIO_IRQ_EN)
package mmio_pkg;
  localparam int REGION_BIT = 11;
  localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
  localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
  localparam logic [2:0] OFF_TMR_CNT  = 3'd2;
  localparam logic [2:0] OFF_TMR_CMP  = 3'd3;
  localparam logic [2:0] OFF_TMR_CTRL = 3'd4;
  localparam logic [2:0] OFF_TMR_STAT = 3'd5;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTOCLR = 1;
  localparam int CTRL_IRQEN   = 2;
  localparam int STAT_MATCH   = 0;
  localparam logic [31:0] CMP_RST_DEF = 32'hFFFF_FFFF;
`ifdef MMIO_IRQ_EN
  localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: 32-bit count/compare timer with sticky W1C match flag (irq_o only with MMIO_IRQ_EN)
module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [31:0] CMP_RST = CMP_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_cnt_i,
  input  logic        wr_cmp_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_stat_i,
  input  logic [31:0] wd_i,
  output logic [31:0] cnt_o,
  output logic [31:0] cmp_o,
  output logic [2:0]  ctrl_o,
  output logic        stat_o
`ifdef MMIO_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        stat_q, stat_d, match;
  // Core writes override counting; a match raises the flag even against a same-cycle clear
  always_comb begin
    match  = ctrl_q[CTRL_EN] && (cnt_q == cmp_q);
    cnt_d  = wr_cnt_i ? wd_i :
             !ctrl_q[CTRL_EN] ? cnt_q :
             (match && ctrl_q[CTRL_AUTOCLR]) ? '0 : cnt_q + 32'd1;
    cmp_d  = wr_cmp_i ? wd_i : cmp_q;
    ctrl_d = wr_ctrl_i ? (wd_i[2:0] & CTRL_WMASK) : ctrl_q;
    stat_d = match | (stat_q & ~(wr_stat_i & wd_i[STAT_MATCH]));
  end
  // Timer register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      cmp_q  <= CMP_RST;
      ctrl_q <= '0;
      stat_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      ctrl_q <= ctrl_d;
      stat_q <= stat_d;
    end
  end
  assign cnt_o  = cnt_q;
  assign cmp_o  = cmp_q;
  assign ctrl_o = ctrl_q;
  assign stat_o = stat_q;
`ifdef MMIO_IRQ_EN
  assign irq_o = stat_q & ctrl_q[CTRL_IRQEN];
`endif
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: word RAM plus GPIO/timer register window on the core data port (irq port with MMIO_IRQ_EN)
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int          DM_DEPTH = 64,
  parameter int          GPIO_W   = 16,
  parameter logic [31:0] CMP_RST  = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_dm,
  input  logic [31:0]       addr,
  input  logic [31:0]       wd_dm,
  output logic [31:0]       rd_dm,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
`ifdef MMIO_IRQ_EN
  ,
  output logic              irq
`endif
);
  localparam int AW = $clog2(DM_DEPTH);
  logic [31:0]       mem [DM_DEPTH];
  logic [AW-1:0]     ram_idx;
  logic [2:0]        reg_off;
  logic              reg_sel, reg_we, unused_addr;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d, sync1_q, sync2_q;
  logic [31:0]       cnt, cmp;
  logic [2:0]        ctrl;
  logic              stat;
  assign ram_idx     = addr[2 +: AW];
  assign reg_off     = addr[4:2];
  assign reg_sel     = addr[REGION_BIT];
  assign reg_we      = we_dm && reg_sel;
  assign unused_addr = ^addr;
  mmio_timer #(.CMP_RST(CMP_RST)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .wr_cnt_i (reg_we && reg_off == OFF_TMR_CNT),
    .wr_cmp_i (reg_we && reg_off == OFF_TMR_CMP),
    .wr_ctrl_i(reg_we && reg_off == OFF_TMR_CTRL),
    .wr_stat_i(reg_we && reg_off == OFF_TMR_STAT),
    .wd_i     (wd_dm),
    .cnt_o    (cnt),
    .cmp_o    (cmp),
    .ctrl_o   (ctrl),
    .stat_o   (stat)
`ifdef MMIO_IRQ_EN
    ,
    .irq_o    (irq)
`endif
  );
  // RAM store port; contents survive reset
  always_ff @(posedge clk) begin
    if (we_dm && !reg_sel) mem[ram_idx] <= wd_dm;
  end
  // GPIO output register next state
  always_comb begin
    gpio_out_d = (reg_we && reg_off == OFF_GPIO_OUT) ? wd_dm[GPIO_W-1:0] : gpio_out_q;
  end
  // GPIO output register and two-stage input synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end
  assign gpio_out = gpio_out_q;
  // Combinational load mux: RAM word or register window
  always_comb begin
    rd_dm = '0;
    if (!reg_sel) rd_dm = mem[ram_idx];
    else begin
      case (reg_off)
        OFF_GPIO_OUT: rd_dm = 32'(gpio_out_q);
        OFF_GPIO_IN:  rd_dm = 32'(sync2_q);
        OFF_TMR_CNT:  rd_dm = cnt;
        OFF_TMR_CMP:  rd_dm = cmp;
        OFF_TMR_CTRL: rd_dm = 32'(ctrl);
        OFF_TMR_STAT: rd_dm = 32'(stat);
        default:      rd_dm = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed table, corner sequences and randomized model check of dmem_mmio_responder
module tb_dmem_mmio_responder;
  localparam int DEPTH = 64;
`ifdef MMIO_IRQ_EN
  localparam logic [31:0] CTRL7_RB = 32'h7;
`else
  localparam logic [31:0] CTRL7_RB = 32'h3;
`endif
  logic        clk, rst, we_dm;
  logic [31:0] addr, wd_dm, rd_dm;
  logic [15:0] gpio_in, gpio_out;
`ifdef MMIO_IRQ_EN
  logic        irq;
`endif
  int checks = 0;
  int errors = 0;

  dmem_mmio_responder #(.DM_DEPTH(DEPTH), .GPIO_W(16), .CMP_RST(32'hFFFF_FFFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .we_dm   (we_dm),
    .addr    (addr),
    .wd_dm   (wd_dm),
    .rd_dm   (rd_dm),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out)
`ifdef MMIO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wd;
    logic [31:0] raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic [31:0] m_mem [DEPTH];
  logic [15:0] m_gout, m_g1, m_g2;
  logic [31:0] m_cnt, m_cmp, m_ctrl, m_stat;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    we_dm = 1'b1;
    addr  = a;
    wd_dm = d;
    tick();
    we_dm = 1'b0;
  endtask

  task automatic ld(input string n, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(n, rd_dm, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!a[11]) return m_mem[(a >> 2) % DEPTH];
    case ((a >> 2) & 32'h7)
      0: return {16'h0, m_gout};
      1: return {16'h0, m_g2};
      2: return m_cnt;
      3: return m_cmp;
      4: return m_ctrl;
      5: return m_stat;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_gout = '0; m_g1 = '0; m_g2 = '0;
    m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_ctrl = '0; m_stat = '0;
  endtask

  task automatic m_clock(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [15:0] g);
    int  off;
    bit  rw, hit;
    off = int'((a >> 2) & 32'h7);
    rw  = w && a[11];
    hit = m_ctrl[0] && (m_cnt == m_cmp);
    if (rw && off == 2) m_cnt = d;
    else if (m_ctrl[0]) m_cnt = (hit && m_ctrl[1]) ? 32'h0 : m_cnt + 1;
    if (hit) m_stat = 1;
    else if (rw && off == 5 && d[0]) m_stat = 0;
    if (rw && off == 3) m_cmp = d;
    if (rw && off == 4) m_ctrl = d & CTRL7_RB;
    if (rw && off == 0) m_gout = d[15:0];
    if (w && !a[11]) m_mem[(a >> 2) % DEPTH] = d;
    m_g2 = m_g1;
    m_g1 = g;
  endtask

  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [15:0] g, input bit do_chk);
    we_dm = w; addr = a; wd_dm = d; gpio_in = g;
    #1;
    if (do_chk) begin
      chk("rand_rd", rd_dm, m_read(a));
      chk("rand_gpio_out", {16'h0, gpio_out}, {16'h0, m_gout});
`ifdef MMIO_IRQ_EN
      chk("rand_irq", {31'h0, irq}, {31'h0, m_stat[0] & m_ctrl[2]});
`endif
    end
    @(posedge clk);
    m_clock(w, a, d, g);
    #1;
    we_dm = 1'b0;
  endtask

  initial begin
    vec_t        tv[$];
    logic [31:0] rst_addr [6];
    logic [31:0] rst_exp [6];
    logic [31:0] a, d;
    logic        w;
    logic [15:0] g;
    rst = 1'b1; we_dm = 1'b0; addr = '0; wd_dm = '0; gpio_in = '0;
    rst_addr = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h810, 32'h814};
    rst_exp  = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    #2;
    for (int i = 0; i < 6; i++) ld("reset_in_rst", rst_addr[i], rst_exp[i]);
    chk("reset_gpio_out", {16'h0, gpio_out}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) ld("reset_after", rst_addr[i], rst_exp[i]);

    tv.push_back('{1'b1, 32'h10,  32'hDEAD_BEEF, 32'h10,   32'hDEAD_BEEF, "ram_store_load"});
    tv.push_back('{1'b0, 32'h0,   32'h0,         32'h1010, 32'hDEAD_BEEF, "ram_alias"});
    tv.push_back('{1'b1, 32'h14,  32'h1234_5678, 32'h10,   32'hDEAD_BEEF, "ram_neighbour"});
    tv.push_back('{1'b1, 32'h800, 32'h1234_00FF, 32'h800,  32'h0000_00FF, "gpio_out_rw"});
    tv.push_back('{1'b1, 32'h818, 32'hFFFF_FFFF, 32'hF818, 32'h0,         "reserved_0x18"});
    tv.push_back('{1'b1, 32'h80C, 32'h5,         32'h80C,  32'h5,         "cmp_rw"});
    tv.push_back('{1'b1, 32'h814, 32'h1,         32'h814,  32'h0,         "stat_w1c_idle"});
    tv.push_back('{1'b1, 32'h810, 32'h7,         32'h810,  CTRL7_RB,      "ctrl_mask"});
    tv.push_back('{1'b0, 32'h0,   32'h0,         32'h808,  32'h1,         "cnt_first_inc"});
    tv.push_back('{1'b1, 32'h810, 32'h0,         32'h808,  32'h2,         "cnt_disable_edge"});
    tv.push_back('{1'b0, 32'h0,   32'h0,         32'h808,  32'h2,         "cnt_hold"});
    foreach (tv[i]) begin
      we_dm = tv[i].we; addr = tv[i].waddr; wd_dm = tv[i].wd;
      tick();
      we_dm = 1'b0;
      ld(tv[i].name, tv[i].raddr, tv[i].exp);
    end

    gpio_in = 16'h00A5;
    tick();
    ld("gpio_sync_1", 32'h804, 32'h0);
    tick();
    ld("gpio_sync_2", 32'h804, 32'hA5);

    st(32'h808, 32'h0); st(32'h814, 32'h1); st(32'h810, 32'h3);
    for (int k = 0; k < 6; k++) begin
      ld("autoclr_cnt", 32'h808, k);
      ld("autoclr_stat0", 32'h814, 32'h0);
      tick();
    end
    ld("autoclr_wrap", 32'h808, 32'h0);
    ld("autoclr_match", 32'h814, 32'h1);
    st(32'h814, 32'h1);
    ld("w1c_clear", 32'h814, 32'h0);
    ld("w1c_cnt", 32'h808, 32'h1);
    st(32'h810, 32'h0);

    st(32'h808, 32'hFFFF_FFFE); st(32'h80C, 32'h3); st(32'h814, 32'h1); st(32'h810, 32'h1);
    for (int k = 0; k < 6; k++) begin
      ld("wrap_cnt", 32'h808, 32'hFFFF_FFFE + k);
      ld("wrap_stat0", 32'h814, 32'h0);
      tick();
    end
    ld("wrap_cnt_after", 32'h808, 32'h4);
    ld("wrap_match", 32'h814, 32'h1);

    st(32'h80C, 32'd10); st(32'h814, 32'h1); st(32'h808, 32'd10);
    ld("prio_cnt_eq", 32'h808, 32'd10);
    ld("prio_stat0", 32'h814, 32'h0);
    st(32'h808, 32'h100);
    ld("prio_cnt_write", 32'h808, 32'h100);
    ld("prio_match_set", 32'h814, 32'h1);
    st(32'h814, 32'h1);
    ld("prio_clear", 32'h814, 32'h0);
    st(32'h808, 32'd10);
    st(32'h814, 32'h1);
    ld("prio_set_beats_w1c", 32'h814, 32'h1);
    ld("prio_cnt_inc", 32'h808, 32'd11);

    st(32'h808, 32'h40); st(32'h800, 32'hFF);
    chk("gpio_out_pin", {16'h0, gpio_out}, 32'hFF);
`ifdef MMIO_IRQ_EN
    st(32'h810, 32'h5);
    chk("irq_asserted", {31'h0, irq}, 32'h1);
`else
    st(32'h810, 32'h7);
    ld("ctrl_no_irqen", 32'h810, 32'h3);
`endif
    ld("cnt_before_rst", 32'h808, 32'h42);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) ld("async_reset", rst_addr[i], rst_exp[i]);
    chk("async_reset_gpio_out", {16'h0, gpio_out}, 32'h0);
`ifdef MMIO_IRQ_EN
    chk("async_reset_irq", {31'h0, irq}, 32'h0);
`endif
    ld("ram_survives_rst", 32'h10, 32'hDEAD_BEEF);
    gpio_in = '0;
    tick();
    rst = 1'b0;
    m_reset();

    for (int i = 0; i < DEPTH; i++) cyc(1'b1, i * 4, $urandom, 16'h0, 1'b0);
    g = '0;
    for (int n = 0; n < 600; n++) begin
      a = $urandom;
      a[11] = ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 12)) : $urandom;
      w = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 3) == 0) g = 16'($urandom);
      cyc(w, a, d, g, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
